// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period and high time of a divided clock (mon_clk)
// at half-cycle resolution of clk_in, checks them against the expected divide
// ratio and 50% duty, and asserts locked after LOCK_CNT consecutive good cycles.
//
// Handshake: meas_valid is a one-cycle pulse with no ready/backpressure; the
// result outputs change only in the cycle meas_valid is high and hold otherwise.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_DIV  = 3,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             meas_valid,
  output logic             period_ok,
  output logic             duty_ok,
  output logic             locked,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int EW = CNT_W + 2;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [EW-1:0] EXP_PER = EW'(2 * EXP_DIV);
  localparam logic [EW-1:0] TOL_E   = EW'(TOL);
  localparam logic [GW-1:0] LOCK_G  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_MEAS = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             s_n_q;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] hc_q, hc_d, hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, pok_q, pok_d, dok_q, dok_d;
  logic             locked_q, locked_d, ovf_q, ovf_d;
  logic [GW-1:0]    good_q, good_d;

  logic             samp_a, samp_b, rise_a, rise_b, sat;
  logic [CNT_W:0]   cnt_a, cnt_b;
  logic [CNT_W-1:0] hi_a, hi_b, meas_per, meas_hi;
  logic [EW-1:0]    per_e, hi2_e, dp, dd;
  logic             p_ok, d_ok;
  logic [GW-1:0]    good_inc;

  // Half-cycle sample of mon_clk taken on the falling edge of clk_in.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) s_n_q <= 1'b0;
    else      s_n_q <= mon_clk;
  end

  // Two-sample edge detection, window counting, checks and FSM next state.
  always_comb begin
    samp_a   = s_n_q;
    samp_b   = mon_clk;
    rise_a   = samp_a & ~prev_q;
    rise_b   = samp_b & ~samp_a;
    // first sample: either opens a new window or extends the current one
    cnt_a    = rise_a ? (CNT_W+1)'(1) : {1'b0, hc_q} + (CNT_W+1)'(1);
    hi_a     = rise_a ? CNT_W'(1) : hi_q + CNT_W'(samp_a);
    // second sample: same, on top of the first
    cnt_b    = rise_b ? (CNT_W+1)'(1) : cnt_a + (CNT_W+1)'(1);
    hi_b     = rise_b ? CNT_W'(1) : hi_a + CNT_W'(samp_b);
    // the closed window excludes the edge sample itself
    meas_per = rise_a ? hc_q : cnt_a[CNT_W-1:0];
    meas_hi  = rise_a ? hi_q : hi_a;
    sat      = cnt_a[CNT_W] | cnt_b[CNT_W];

    per_e    = {2'b00, meas_per};
    hi2_e    = {1'b0, meas_hi, 1'b0};
    dp       = (per_e >= EXP_PER) ? per_e - EXP_PER : EXP_PER - per_e;
    dd       = (hi2_e >= per_e) ? hi2_e - per_e : per_e - hi2_e;
    p_ok     = (dp <= TOL_E);
    d_ok     = (dd <= TOL_E);
    good_inc = (good_q == LOCK_G) ? good_q : good_q + GW'(1);

    state_d  = state_q;
    prev_d   = samp_b;
    hc_d     = hc_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    pok_d    = pok_q;
    dok_d    = dok_q;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    good_d   = good_q;

    if (state_q != S_IDLE && !en) begin
      // partial window dropped; lock and overflow history cleared, results held
      state_d  = S_IDLE;
      hc_d     = '0;
      hi_d     = '0;
      good_d   = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hc_d     = '0;
          hi_d     = '0;
          good_d   = '0;
          locked_d = 1'b0;
          ovf_d    = 1'b0;
          if (en) state_d = S_ARM;
        end
        S_ARM: begin
          if (rise_a | rise_b) begin
            hc_d    = cnt_b[CNT_W-1:0];
            hi_d    = hi_b;
            state_d = S_MEAS;
          end
        end
        S_MEAS: begin
          if (sat) begin
            // period too long to measure: no result, restart on next edge
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            hc_d     = '0;
            hi_d     = '0;
            state_d  = S_ARM;
          end else begin
            hc_d = cnt_b[CNT_W-1:0];
            hi_d = hi_b;
            if (rise_a | rise_b) begin
              period_d = meas_per;
              high_d   = meas_hi;
              pok_d    = p_ok;
              dok_d    = d_ok;
              valid_d  = 1'b1;
              good_d   = (p_ok & d_ok) ? good_inc : '0;
              locked_d = (p_ok & d_ok) && (good_inc == LOCK_G);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All posedge state, asynchronously cleared.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prev_q   <= 1'b0;
      hc_q     <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      pok_q    <= 1'b0;
      dok_q    <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      hc_q     <= hc_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      pok_q    <= pok_d;
      dok_q    <= dok_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      good_q   <= good_d;
    end
  end

  assign period_hc  = period_q;
  assign high_hc    = high_q;
  assign meas_valid = valid_q;
  assign period_ok  = pok_q;
  assign duty_ok    = dok_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;
  assign state_dbg  = state_q;

endmodule
